// File: rtl/icache_pkg.sv
// Shared types, constants and address-split width helpers for the instruction cache.
// Widths are derived from the LINES / WORDS_PER_LINE parameters of the cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icache_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int off_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words_per_line);
        return 32 - 2 - $clog2(lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: async read at one index, sync word write, tag/valid set, clear-all.
// Latency: read is combinational, writes land at the rising edge; no backpressure (always accepts).
// Clear-all takes priority over a same-cycle set so a flushed fill never becomes valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = idx_bits(LINES),
    parameter int OFF_W          = off_bits(WORDS_PER_LINE),
    parameter int TAG_W          = tag_bits(LINES, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_word,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_all
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];
    logic [31:0]      data_d [LINES][WORDS_PER_LINE];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_off] = wr_word;
        end
        if (set_en) begin
            tag_d[set_idx]   = set_tag;
            valid_d[set_idx] = 1'b1;
        end
        if (clr_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with whole-line refill from a multi-cycle memory.
// Latency: 0 cycles on hit; a miss stalls for 2 + WORDS_PER_LINE cycles plus grant/beat gaps.
// Backpressure: stall holds the core; mem_req is held until mem_gnt, rvalid beats are taken as they come.
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic [31:0] Instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = off_bits(WORDS_PER_LINE);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    icache_state_t    state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             flush_pend_q, flush_pend_d;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             pc_unused;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_word;
    logic             wr_en;
    logic             set_en;
    logic             clr_all;
    logic             hit;

    assign pc_off    = PC[2 +: OFF_W];
    assign pc_idx    = PC[2 + OFF_W +: IDX_W];
    assign pc_tag    = PC[2 + OFF_W + IDX_W +: TAG_W];
    assign miss_idx  = miss_addr_q[2 + OFF_W +: IDX_W];
    assign miss_tag  = miss_addr_q[2 + OFF_W + IDX_W +: TAG_W];
    assign pc_unused = ^PC[1:0];

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .OFF_W          (OFF_W),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx),
        .rd_off   (pc_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .wr_en    (wr_en),
        .wr_idx   (miss_idx),
        .wr_off   (beat_q),
        .wr_word  (mem_rdata),
        .set_en   (set_en),
        .set_idx  (miss_idx),
        .set_tag  (miss_tag),
        .clr_all  (clr_all)
    );

    // Only IDLE may hit, so a line being refilled is never served early.
    assign hit   = rd_valid && (rd_tag == pc_tag) && (state_q == IDLE);
    assign stall = !hit;
    assign Instr = hit ? rd_word : NOP_INSTR;

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        mem_req      = 1'b0;
        mem_addr     = 32'h0;
        wr_en        = 1'b0;
        set_en       = 1'b0;
        clr_all      = 1'b0;
        case (state_q)
            IDLE: begin
                clr_all = flush;
                if (!hit) begin
                    miss_addr_d = {PC[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                    beat_d      = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr_q;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rvalid) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        // A flush seen at any point of the fill, including this beat, discards the line.
                        if (flush_pend_q || flush) begin
                            clr_all = 1'b1;
                        end else begin
                            set_en = 1'b1;
                        end
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            miss_addr_q  <= 32'h0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache; backing memory returns byte address A as A + 32'h1000_0000.
module tb_instr_cache;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BIAS = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        flush;
    logic [31:0] Instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    instr_cache #(
        .LINES          (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (PC),
        .flush      (flush),
        .Instr      (Instr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side driver. Called at a negedge with PC already applied; returns #1 after the
    // negedge that follows the last driven beat, with all memory inputs idle.
    task automatic do_fill(input int gnt_delay, input int gap_after, input int flush_beat,
                           input int max_beats, output int stall_cyc, output int req_cyc,
                           output logic [31:0] req_addr, output bit timeout);
        int  beat     = 0;
        int  waited   = 0;
        int  cyc      = 0;
        bit  in_fill  = 1'b0;
        bit  gap_done = 1'b0;
        stall_cyc = 0;
        req_cyc   = 0;
        req_addr  = 32'h0;
        timeout   = 1'b0;
        forever begin
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            flush      = 1'b0;
            if (beat == max_beats) break;
            if (cyc > 60) begin
                timeout = 1'b1;
                break;
            end
            cyc++;
            if (stall) stall_cyc++;
            if (mem_req) begin
                req_cyc++;
                req_addr = mem_addr;
                if (waited == gnt_delay) begin
                    mem_gnt = 1'b1;
                    in_fill = 1'b1;
                end else begin
                    waited++;
                end
            end else if (in_fill) begin
                if (gap_after >= 0 && beat == gap_after + 1 && !gap_done) begin
                    gap_done = 1'b1;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = req_addr + BIAS + 32'(4 * beat);
                    if (beat == flush_beat) flush = 1'b1;
                    beat++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; PC = 32'h0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall: got %b want 1", stall); end
        vectors++;
        if (Instr !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h want %h", Instr, NOP); end
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++; $display("FAIL reset_mem: got req %b addr %h want 0 0", mem_req, mem_addr);
        end
    endtask

    task automatic test_cold_miss();
        int sc, rc; logic [31:0] ra; bit to;
        @(negedge clk);
        rst = 1'b0; PC = 32'h40;
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL cold_timeout: got timeout want fill"); end
        vectors++;
        if (sc != 6) begin miscompares++; $display("FAIL cold_stall_cycles: got %0d want 6", sc); end
        vectors++;
        if (ra !== 32'h40 || rc != 1) begin
            miscompares++; $display("FAIL cold_req: got addr %h cycles %0d want 00000040 1", ra, rc);
        end
        vectors++;
        if (stall !== 1'b0 || Instr !== 32'h1000_0040) begin
            miscompares++; $display("FAIL cold_hit: got stall %b instr %h want 0 10000040", stall, Instr);
        end
    endtask

    task automatic test_same_line_hits();
        logic [31:0] addrs [3] = '{32'h44, 32'h48, 32'h4C};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            PC = addrs[i];
            #1;
            vectors++;
            if (stall !== 1'b0 || Instr !== addrs[i] + BIAS || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL line_hit_%h: got stall %b instr %h req %b want 0 %h 0",
                         addrs[i], stall, Instr, mem_req, addrs[i] + BIAS);
            end
        end
    endtask

    task automatic test_conflict();
        int sc, rc; logic [31:0] ra; bit to;
        @(negedge clk);
        PC = 32'h140;
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || ra !== 32'h140 || sc != 6) begin
            miscompares++; $display("FAIL conflict_fill: got addr %h stall %0d to %b want 00000140 6 0", ra, sc, to);
        end
        vectors++;
        if (stall !== 1'b0 || Instr !== 32'h1000_0140) begin
            miscompares++; $display("FAIL conflict_hit: got stall %b instr %h want 0 10000140", stall, Instr);
        end
        @(negedge clk);
        PC = 32'h40;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL conflict_evict: got stall %b want 1", stall); end
        @(negedge clk);
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || stall !== 1'b0 || Instr !== 32'h1000_0040) begin
            miscompares++; $display("FAIL conflict_refill: got stall %b instr %h want 0 10000040", stall, Instr);
        end
    endtask

    task automatic test_gnt_delay_gap();
        int sc, rc; logic [31:0] ra; bit to;
        @(negedge clk);
        PC = 32'h1C8;
        do_fill(3, 1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || rc != 4 || ra !== 32'h1C0) begin
            miscompares++; $display("FAIL delay_req: got cycles %0d addr %h to %b want 4 000001c0 0", rc, ra, to);
        end
        vectors++;
        if (sc != 10) begin miscompares++; $display("FAIL delay_stall_cycles: got %0d want 10", sc); end
        vectors++;
        if (stall !== 1'b0 || Instr !== 32'h1000_01C8) begin
            miscompares++; $display("FAIL delay_hit: got stall %b instr %h want 0 100001c8", stall, Instr);
        end
        @(negedge clk);
        PC = 32'h1CC;
        #1;
        vectors++;
        if (stall !== 1'b0 || Instr !== 32'h1000_01CC) begin
            miscompares++; $display("FAIL delay_last_word: got stall %b instr %h want 0 100001cc", stall, Instr);
        end
    endtask

    task automatic test_flush_idle();
        int sc, rc; logic [31:0] ra; bit to;
        @(negedge clk);
        flush = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0 || Instr !== 32'h1000_01CC) begin
            miscompares++; $display("FAIL flush_same_cycle: got stall %b instr %h want 0 100001cc", stall, Instr);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL flush_idle_miss: got stall %b want 1", stall); end
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || stall !== 1'b0 || Instr !== 32'h1000_01CC) begin
            miscompares++; $display("FAIL flush_idle_refill: got stall %b instr %h want 0 100001cc", stall, Instr);
        end
    endtask

    task automatic test_flush_fill();
        int sc, rc; logic [31:0] ra; bit to;
        @(negedge clk);
        PC = 32'h240;
        do_fill(0, -1, 2, 4, sc, rc, ra, to);
        vectors++;
        if (to || stall !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL flush_fill_novalid: got stall %b req %b want 1 0", stall, mem_req);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h240) begin
            miscompares++; $display("FAIL flush_fill_rereq: got req %b addr %h want 1 00000240", mem_req, mem_addr);
        end
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || stall !== 1'b0 || Instr !== 32'h1000_0240) begin
            miscompares++; $display("FAIL flush_fill_hit: got stall %b instr %h want 0 10000240", stall, Instr);
        end
    endtask

    task automatic test_reset_mid_fill();
        int sc, rc; logic [31:0] ra; bit to;
        @(negedge clk);
        PC = 32'h80;
        do_fill(0, -1, -1, 2, sc, rc, ra, to);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (to || stall !== 1'b1 || Instr !== NOP || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_fill_outputs: got stall %b instr %h req %b addr %h want 1 00000013 0 0",
                     stall, Instr, mem_req, mem_addr);
        end
        PC = 32'h40;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_flushed_line: got stall %b want 1", stall); end
        @(negedge clk);
        #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            miscompares++; $display("FAIL rst_rereq: got req %b addr %h want 1 00000040", mem_req, mem_addr);
        end
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || stall !== 1'b0 || Instr !== 32'h1000_0040) begin
            miscompares++; $display("FAIL rst_refill: got stall %b instr %h want 0 10000040", stall, Instr);
        end
        @(negedge clk);
        PC = 32'h4C;
        #1;
        vectors++;
        if (stall !== 1'b0 || Instr !== 32'h1000_004C) begin
            miscompares++; $display("FAIL rst_refill_word3: got stall %b instr %h want 0 1000004c", stall, Instr);
        end
        @(negedge clk);
        PC = 32'h84;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_partial_line: got stall %b want 1", stall); end
        @(negedge clk);
        do_fill(0, -1, -1, 4, sc, rc, ra, to);
        vectors++;
        if (to || stall !== 1'b0 || Instr !== 32'h1000_0084) begin
            miscompares++; $display("FAIL rst_partial_refill: got stall %b instr %h want 0 10000084", stall, Instr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_cold_miss();
        test_same_line_hits();
        test_conflict();
        test_gnt_delay_gap();
        test_flush_idle();
        test_flush_fill();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the program counter and the datapath's instruction decode. It looks up `PC` combinationally and returns `Instr` in the same cycle on a hit. On a miss it asserts `stall`, fetches the whole line from a multi-cycle backing instruction memory, and then serves the hit. A `flush` input invalidates all lines, for fence.i and self-modifying program loads.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PC` in 32: fetch byte address; bits [1:0] ignored.
- `flush` in 1: invalidate all lines.
- `Instr` out 32: instruction word; meaningful only when `stall`=0.
- `stall` out 1: high when `Instr` is not valid this cycle; the core holds `PC` while high.
- `mem_req` out 1: line-fetch request, held until granted.
- `mem_addr` out 32: line-aligned byte address of the requested line.
- `mem_gnt` in 1: memory accepts the request in the cycle where `mem_req`&`mem_gnt`.
- `mem_rvalid` in 1: one returned word this cycle.
- `mem_rdata` in 32: returned word, in ascending order starting at word 0 of the line.

## Operation
- Address split:
  - OFF = log2(WORDS_PER_LINE) bits at [OFF+1:2].
  - IDX = log2(LINES) bits directly above OFF.
  - TAG = remaining upper bits.
- Per line state: `valid`, `tag`, `WORDS_PER_LINE` data words.
- `hit` = `valid[IDX]` && `tag[IDX]`==TAG(`PC`) && state==IDLE.
- `Instr` = `data[IDX][OFF]` on hit, else 32'h0000_0013 (NOP).
- `stall` = !`hit`.
- FSM states IDLE, REQ, FILL:
  - **IDLE:**
    - On miss, latch `miss_addr` = `PC` with OFF and [1:0] zeroed, clear `beat`, and go to REQ.
    - On hit, stay.
  - **REQ:**
    - `mem_req`=1 and `mem_addr`=`miss_addr`.
    - On `mem_gnt`, go to FILL; else stay.
  - **FILL:**
    - Each `mem_rvalid` writes `mem_rdata` to `data[IDX(miss_addr)][beat]` and increments `beat`.
    - On the beat where `beat`==WORDS_PER_LINE-1, write `tag` and set `valid`, unless a flush is pending. Then go to IDLE.
- `mem_req`=0 and `mem_addr`=0 outside REQ.
- `mem_rvalid` is ignored in IDLE and REQ.
- A line is never marked valid until all its words are written. A partially filled line is never hit.
- Flush:
  - **In IDLE:** all `valid` are cleared at the edge. The combinational hit in that same cycle still returns the old data.
  - **In REQ or FILL:** sets `flush_pend`. The fill still completes. At completion, all `valid` are cleared, the new line is not validated, and `flush_pend` is cleared. The return to IDLE then misses again.
- A miss on a valid line with a different tag (conflict) overwrites that line.
- `PC` changes while `stall` is high are a protocol violation. The fill uses `miss_addr`, not `PC`.

## Timing
- Reset values:
  - state=IDLE, all `valid`=0, `beat`=0, `flush_pend`=0.
  - `mem_req`=0, `mem_addr`=0.
  - `stall`=1 (cold cache), `Instr`=NOP.
  - Tag and data arrays are not reset.
- Hit latency: 0 cycles (combinational `PC`→`Instr`).
- Miss penalty with immediate grant and back-to-back `rvalid`, for W words:
  - Cycle 0: miss detected.
  - Cycle 1: REQ, grant.
  - Cycles 2..W+1: FILL beats.
  - Cycle W+2: IDLE, hit, `stall`=0.
  - For W=4, `stall` is high for 6 cycles.
- Each cycle of grant delay or gap between `rvalid` beats adds one stall cycle.
- `rst` mid-REQ/FILL:
  - Abandons the fill and returns to IDLE; all `valid` are cleared.
  - Late beats are ignored because they arrive outside FILL.
  - Backing memory is reset by the same `rst`.
- `flush` and the last beat in the same cycle: treated as a pending flush, so the line is not validated.

## Structure
- Shared package `icache_pkg`:
  - State enum `icache_state_t` {IDLE, REQ, FILL}.
  - Constant `NOP_INSTR` = 32'h0000_0013.
  - Functions deriving OFF/IDX/TAG widths from the parameters.
- One natural sub-module, `icache_array`:
  - Valid/tag/data storage.
  - Asynchronous read at an index.
  - Synchronous word write.
  - Tag/valid set port and clear-all port.
- The FSM, address split and memory interface stay in `instr_cache`.

## Test plan
Backing memory model returns the word at byte address A as A+32'h1000_0000. Default parameters.

- **Cold miss then hit:** `PC`=32'h0000_0040 after reset, gnt immediate.
  - `stall` is high 6 cycles.
  - `mem_addr`=32'h40 in REQ.
  - Then `Instr`=32'h1000_0040, `stall`=0.
- **Same-line hits:** after the line at 32'h40 is filled, `PC`=32'h44/48/4C each return 32'h1000_0044/48/4C in the same cycle with `stall`=0 and no `mem_req`.
- **Conflict miss:** `PC`=32'h0000_0140 (same IDX, new tag) refills. A return to 32'h40 misses again.
- **Grant delay and beat gaps:** `mem_gnt` is withheld 3 cycles and one idle cycle is inserted between beats 1 and 2.
  - `mem_req` is held 4 cycles.
  - `stall` lasts 10 cycles.
  - Data is correct.
- **Flush:**
  - Flush in IDLE: the next cycle at a previously hit `PC` misses.
  - Flush during FILL beat 2: the fill completes, then `stall` stays high and a second `mem_req` is issued for the same line.
- **Reset mid-fill:** `rst` after beat 1.
  - Outputs are at reset values the next cycle.
  - Remaining `rvalid` beats are ignored.
  - A subsequent `PC`=32'h40 misses and refills correctly.
